// File: rtl/pcm_channel_encoder_if.sv
// Channel-side bus of the PCM word encoder: config request, channel selects, data buses and line output.
// The master modport is the encoder; the slave side is the channel/ADC environment.
interface pcm_channel_encoder_if #(
    parameter int WORD_WIDTH      = 8,
    parameter int ADC_WIDTH       = 14,
    parameter int ID_WIDTH        = 6,
    parameter int CS_WIDTH        = 8,
    parameter int FRAME_CNT_WIDTH = 16
);
    logic [31:0]                Configer_Word;
    logic                       Config_Req;
    logic [4:0]                 Bit_Index;
    logic [ADC_WIDTH-1:0]       DataBus_Analog;
    logic                       CS_Analog;
    logic [ID_WIDTH-1:0]        ID_Analog;
    logic [WORD_WIDTH-1:0]      DataBus_Digtal;
    logic [CS_WIDTH-1:0]        CS_Digtal;
    logic [WORD_WIDTH-1:0]      DataBus_Extern;
    logic [CS_WIDTH-1:0]        CS_Extern;
    logic [FRAME_CNT_WIDTH-1:0] Counter_Frame;
    logic                       PCM;

    modport master (
        input  Configer_Word, DataBus_Analog, DataBus_Digtal, DataBus_Extern, Counter_Frame,
        output Config_Req, Bit_Index, CS_Analog, ID_Analog, CS_Digtal, CS_Extern, PCM
    );

    modport slave (
        output Configer_Word, DataBus_Analog, DataBus_Digtal, DataBus_Extern, Counter_Frame,
        input  Config_Req, Bit_Index, CS_Analog, ID_Analog, CS_Digtal, CS_Extern, PCM
    );
endinterface

// File: rtl/pcm_channel_encoder.sv
// Per-channel PCM word encoder: bit counter, one-word-ahead config pipeline, channel selects,
// data capture at the word wrap, MSB-first serialisation with optional parity and NRZ-L/M/S coding.
module pcm_channel_encoder #(
    parameter int WORD_WIDTH      = 8,
    parameter int ADC_WIDTH       = 14,
    parameter int ID_WIDTH        = 6,
    parameter int CS_WIDTH        = 8,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input logic                  CLOCK_Bit,
    input logic                  RESET,
    pcm_channel_encoder_if.master bus
);
    typedef enum logic [2:0] {
        CH_ANALOG_H    = 3'b000,
        CH_ANALOG_L    = 3'b001,
        CH_ANALOG_FREE = 3'b010,
        CH_DIGITAL     = 3'b011,
        CH_EXTERN      = 3'b100,
        CH_FIXED       = 3'b101,
        CH_COUNTER_H   = 3'b110,
        CH_COUNTER_L   = 3'b111
    } chan_type_e;

    typedef enum logic [1:0] {
        LC_NRZ_L = 2'b00,
        LC_NRZ_M = 2'b01,
        LC_NRZ_S = 2'b10,
        LC_RSVD  = 2'b11
    } line_code_e;

    localparam int          LOW_WIDTH   = ADC_WIDTH - WORD_WIDTH;
    localparam int          EXT_WIDTH   = ADC_WIDTH + WORD_WIDTH;
    localparam logic [4:0]  K_DATA_LAST = 5'(WORD_WIDTH - 1);
    localparam logic [4:0]  K_PARITY    = 5'(WORD_WIDTH);
    localparam logic [3:0]  SHIFT_MAX   = (ADC_WIDTH - 1 > 15) ? 4'd15 : 4'(ADC_WIDTH - 1);
    localparam logic [15:0] RESET_EXTRA = 16'hAAAA;

    logic [4:0]                 k_q;
    chan_type_e                 pend_type_q;
    logic [3:0]                 pend_shift_q;
    logic [15:0]                pend_extra_q;
    line_code_e                 pend_lc_q;
    logic                       pend_par_en_q;
    logic                       pend_par_odd_q;

    line_code_e                 tx_lc_q;
    logic                       tx_par_en_q;
    logic                       tx_par_bit_q;
    logic [WORD_WIDTH-1:0]      shift_q;
    logic [ADC_WIDTH-1:0]       sample_q;
    logic                       pcm_q;

    logic                       cs_analog_q;
    logic [ID_WIDTH-1:0]        id_analog_q;
    logic [CS_WIDTH-1:0]        cs_digital_q;
    logic [CS_WIDTH-1:0]        cs_extern_q;

    logic [4:0]                 k_last;
    logic                       wrap;
    logic [3:0]                 shift_amt;
    logic [LOW_WIDTH+WORD_WIDTH-1:0] low_ext;
    logic [EXT_WIDTH-1:0]       free_ext;
    logic [WORD_WIDTH-1:0]      analog_low;
    logic [WORD_WIDTH-1:0]      analog_free;
    logic [WORD_WIDTH-1:0]      word_d;
    line_code_e                 lc_now;
    logic                       tx_bit;
    logic                       line_level;

    // Word length follows the parity setting of the word on the line, so L changes only at a wrap.
    assign k_last = tx_par_en_q ? K_PARITY : K_DATA_LAST;
    assign wrap   = (k_q == k_last);

    assign shift_amt = (pend_shift_q > SHIFT_MAX) ? SHIFT_MAX : pend_shift_q;

    generate
        if (LOW_WIDTH > 0) begin : g_low
            assign low_ext = {sample_q[LOW_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
        end else begin : g_no_low
            assign low_ext = '0;
        end
    endgenerate

    assign analog_low  = low_ext[LOW_WIDTH+WORD_WIDTH-1 -: WORD_WIDTH];
    assign free_ext    = {bus.DataBus_Analog, {WORD_WIDTH{1'b0}}} << shift_amt;
    assign analog_free = free_ext[EXT_WIDTH-1 -: WORD_WIDTH];

    always_comb begin
        word_d = '0;
        case (pend_type_q)
            CH_ANALOG_H:    word_d = bus.DataBus_Analog[ADC_WIDTH-1 -: WORD_WIDTH];
            CH_ANALOG_L:    word_d = analog_low;
            CH_ANALOG_FREE: word_d = analog_free;
            CH_DIGITAL:     word_d = bus.DataBus_Digtal;
            CH_EXTERN:      word_d = bus.DataBus_Extern;
            CH_FIXED:       word_d = pend_extra_q[WORD_WIDTH-1:0];
            CH_COUNTER_H:   word_d = bus.Counter_Frame[FRAME_CNT_WIDTH-1 -: WORD_WIDTH];
            CH_COUNTER_L:   word_d = bus.Counter_Frame[WORD_WIDTH-1:0];
            default:        word_d = '0;
        endcase
    end

    // At the wrap the first bit and its line code come straight from the word being captured.
    always_comb begin
        lc_now     = tx_lc_q;
        tx_bit     = 1'b0;
        line_level = 1'b0;
        if (wrap) begin
            lc_now = pend_lc_q;
            tx_bit = word_d[WORD_WIDTH-1];
        end else if ((k_q + 5'd1) < K_PARITY) begin
            tx_bit = shift_q[WORD_WIDTH-1];
        end else begin
            tx_bit = tx_par_bit_q;
        end
        case (lc_now)
            LC_NRZ_M: line_level = pcm_q ^ tx_bit;
            LC_NRZ_S: line_level = pcm_q ^ ~tx_bit;
            default:  line_level = tx_bit;
        endcase
    end

    always_ff @(posedge CLOCK_Bit) begin
        if (RESET) begin
            k_q            <= K_DATA_LAST;
            pend_type_q    <= CH_FIXED;
            pend_shift_q   <= '0;
            pend_extra_q   <= RESET_EXTRA;
            pend_lc_q      <= LC_NRZ_L;
            pend_par_en_q  <= 1'b0;
            pend_par_odd_q <= 1'b0;
        end else begin
            k_q <= wrap ? 5'd0 : k_q + 5'd1;
            if (k_q == 5'd1) begin
                pend_lc_q      <= line_code_e'(bus.Configer_Word[31:30]);
                pend_par_en_q  <= bus.Configer_Word[29];
                pend_par_odd_q <= bus.Configer_Word[28];
                pend_type_q    <= chan_type_e'(bus.Configer_Word[22:20]);
                pend_shift_q   <= bus.Configer_Word[19:16];
                pend_extra_q   <= bus.Configer_Word[15:0];
            end
        end
    end

    always_ff @(posedge CLOCK_Bit) begin
        if (RESET) begin
            cs_analog_q  <= 1'b0;
            id_analog_q  <= '0;
            cs_digital_q <= '0;
            cs_extern_q  <= '0;
        end else if (k_q == 5'd1) begin
            cs_analog_q  <= 1'b0;
            cs_digital_q <= '0;
            cs_extern_q  <= '0;
        end else if (k_q == 5'd2) begin
            case (pend_type_q)
                CH_ANALOG_H, CH_ANALOG_FREE: begin
                    cs_analog_q <= 1'b1;
                    id_analog_q <= pend_extra_q[ID_WIDTH-1:0];
                end
                CH_DIGITAL: cs_digital_q <= pend_extra_q[CS_WIDTH-1:0];
                CH_EXTERN:  cs_extern_q  <= pend_extra_q[CS_WIDTH-1:0];
                default:    ;
            endcase
        end
    end

    // pcm_q doubles as the NRZ level register, so it stays continuous across words and code changes.
    always_ff @(posedge CLOCK_Bit) begin
        if (RESET) begin
            tx_lc_q      <= LC_NRZ_L;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            shift_q      <= '0;
            sample_q     <= '0;
            pcm_q        <= 1'b0;
        end else begin
            pcm_q <= line_level;
            if (wrap) begin
                shift_q      <= {word_d[WORD_WIDTH-2:0], 1'b0};
                tx_lc_q      <= pend_lc_q;
                tx_par_en_q  <= pend_par_en_q;
                tx_par_bit_q <= (^word_d) ^ pend_par_odd_q;
                if (pend_type_q == CH_ANALOG_H) begin
                    sample_q <= bus.DataBus_Analog;
                end
            end else begin
                shift_q <= {shift_q[WORD_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign bus.PCM        = pcm_q;
    assign bus.Config_Req = (k_q == 5'd0);
    assign bus.Bit_Index  = k_q;
    assign bus.CS_Analog  = cs_analog_q;
    assign bus.ID_Analog  = id_analog_q;
    assign bus.CS_Digtal  = cs_digital_q;
    assign bus.CS_Extern  = cs_extern_q;

    logic unused_bits;
    assign unused_bits = ^{bus.Configer_Word[27:23], pend_extra_q, sample_q, low_ext, free_ext,
                           bus.Counter_Frame};
endmodule

// File: tb/tb_pcm_channel_encoder.sv
// Self-checking bench for pcm_channel_encoder: constant vector table, hand-written corner sequences,
// and randomized traffic compared per cycle against a word-level reference model with a bit queue.
module tb_pcm_channel_encoder;
    localparam int WW = 8;
    localparam int AW = 14;
    localparam int IW = 6;
    localparam int CW = 8;
    localparam int FW = 16;

    logic CLOCK_Bit = 1'b0;
    logic RESET     = 1'b1;

    pcm_channel_encoder_if #(.WORD_WIDTH(WW), .ADC_WIDTH(AW), .ID_WIDTH(IW), .CS_WIDTH(CW),
                             .FRAME_CNT_WIDTH(FW)) bus ();

    pcm_channel_encoder #(.WORD_WIDTH(WW), .ADC_WIDTH(AW), .ID_WIDTH(IW), .CS_WIDTH(CW),
                          .FRAME_CNT_WIDTH(FW)) dut (
        .CLOCK_Bit (CLOCK_Bit),
        .RESET     (RESET),
        .bus       (bus)
    );

    always #5 CLOCK_Bit = ~CLOCK_Bit;

    typedef struct packed {
        logic [31:0]   cfg;
        logic [AW-1:0] adc;
        logic [WW-1:0] dig;
        logic [WW-1:0] ext;
        logic [FW-1:0] cnt;
        logic [WW-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0]   m_pend;
    int            mk;
    bit            mv;
    logic [AW-1:0] m_held;
    bit            q[$];
    logic          m_csa;
    logic [IW-1:0] m_id;
    logic [CW-1:0] m_csd;
    logic [CW-1:0] m_cse;

    function automatic logic [31:0] mk_cfg(input logic [1:0] lc, input logic pe, input logic po,
                                           input logic [2:0] typ, input logic [3:0] sh,
                                           input logic [15:0] e);
        return {lc, pe, po, 5'b0, typ, sh, e};
    endfunction

    function automatic logic [WW-1:0] chan_data(input logic [31:0] cfg, input logic [AW-1:0] adc,
                                                input logic [AW-1:0] held, input logic [WW-1:0] dig,
                                                input logic [WW-1:0] ext, input logic [FW-1:0] cnt);
        longint s;
        longint v;
        s = longint'(cfg[19:16]);
        if (s > AW - 1) s = AW - 1;
        case (cfg[22:20])
            3'd0:    v = longint'(adc) >> (AW - WW);
            3'd1:    v = ((longint'(held) % (longint'(1) << (AW - WW))) << WW) >> (AW - WW);
            3'd2:    v = ((longint'(adc) << WW) << s) >> AW;
            3'd3:    v = longint'(dig);
            3'd4:    v = longint'(ext);
            3'd5:    v = longint'(cfg[15:0]);
            3'd6:    v = longint'(cnt) >> (FW - WW);
            default: v = longint'(cnt);
        endcase
        return v[WW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_coded(input bit b, input logic [1:0] lc);
        case (lc)
            2'b01:   mv = mv ^ b;
            2'b10:   mv = mv ^ !b;
            default: mv = b;
        endcase
        q.push_back(mv);
    endtask

    task automatic model_reset();
        q.delete();
        mk     = WW - 1;
        mv     = 1'b0;
        m_pend = mk_cfg(2'd0, 1'b0, 1'b0, 3'd5, 4'd0, 16'hAAAA);
        m_held = '0;
        m_csa  = 1'b0;
        m_id   = '0;
        m_csd  = '0;
        m_cse  = '0;
    endtask

    // One bit clock: advance the model through the coming edge, then compare every output.
    task automatic cycle();
        logic [WW-1:0] d;
        bit rst;
        bit wrap;
        logic exp_pcm;
        rst  = RESET;
        wrap = (q.size() == 0);
        if (rst) begin
            model_reset();
        end else begin
            if (wrap) begin
                d = chan_data(m_pend, bus.DataBus_Analog, m_held, bus.DataBus_Digtal,
                              bus.DataBus_Extern, bus.Counter_Frame);
                if (m_pend[22:20] == 3'b000) m_held = bus.DataBus_Analog;
                for (int i = WW - 1; i >= 0; i--) push_coded(d[i], m_pend[31:30]);
                if (m_pend[29]) push_coded((^d) ^ m_pend[28], m_pend[31:30]);
            end
            if (mk == 1) begin
                m_pend = bus.Configer_Word;
                m_csa  = 1'b0;
                m_csd  = '0;
                m_cse  = '0;
            end else if (mk == 2) begin
                case (m_pend[22:20])
                    3'b000, 3'b010: begin m_csa = 1'b1; m_id = m_pend[IW-1:0]; end
                    3'b011:  m_csd = m_pend[CW-1:0];
                    3'b100:  m_cse = m_pend[CW-1:0];
                    default: ;
                endcase
            end
            mk = wrap ? 0 : mk + 1;
        end
        @(posedge CLOCK_Bit);
        #1;
        exp_pcm = 1'b0;
        if (!rst && q.size() > 0) exp_pcm = q.pop_front();
        chk("pcm", 32'(bus.PCM), 32'(exp_pcm));
        chk("bit_index", 32'(bus.Bit_Index), mk);
        chk("config_req", 32'(bus.Config_Req), (!rst && mk == 0) ? 32'd1 : 32'd0);
        chk("cs_analog", 32'(bus.CS_Analog), 32'(m_csa));
        chk("id_analog", 32'(bus.ID_Analog), 32'(m_id));
        chk("cs_digtal", 32'(bus.CS_Digtal), 32'(m_csd));
        chk("cs_extern", 32'(bus.CS_Extern), 32'(m_cse));
    endtask

    task automatic wait_k(input int target);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (mk != target && n < 40);
        if (mk != target) begin
            checks++;
            errors++;
            $display("FAIL wait_k actual=%0d required=%0d", mk, target);
        end
    endtask

    task automatic collect(input int nbits, output logic [31:0] w);
        w = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) cycle();
            w = {w[30:0], bus.PCM};
        end
    endtask

    task automatic req_period(output int p);
        p = 0;
        do begin
            cycle();
            p++;
        end while (!bus.Config_Req && p < 40);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cycle();
        cycle();
        RESET = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        logic [31:0] w;
        bus.Configer_Word  = vecs[idx].cfg;
        bus.DataBus_Analog = vecs[idx].adc;
        bus.DataBus_Digtal = vecs[idx].dig;
        bus.DataBus_Extern = vecs[idx].ext;
        bus.Counter_Frame  = vecs[idx].cnt;
        wait_k(2);
        wait_k(0);
        collect(WW, w);
        chk($sformatf("vec%0d_word", idx), w, 32'(vecs[idx].exp));
    endtask

    initial begin
        logic [31:0] w;
        int p;

        vecs[0] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd5, 4'd0, 16'h00A5), adc: 14'h2ABC, dig: 8'h00, ext: 8'h00, cnt: 16'h0000, exp: 8'hA5};
        vecs[1] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd0, 4'd0, 16'h0015), adc: 14'h2ABC, dig: 8'h00, ext: 8'h00, cnt: 16'h0000, exp: 8'hAA};
        vecs[2] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd1, 4'd0, 16'h0015), adc: 14'h2ABC, dig: 8'h00, ext: 8'h00, cnt: 16'h0000, exp: 8'hF0};
        vecs[3] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd2, 4'd2, 16'h0015), adc: 14'h2ABC, dig: 8'h00, ext: 8'h00, cnt: 16'h0000, exp: 8'hAB};
        vecs[4] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd2, 4'd15, 16'h0021), adc: 14'h0001, dig: 8'h00, ext: 8'h00, cnt: 16'h0000, exp: 8'h80};
        vecs[5] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd3, 4'd0, 16'h0033), adc: 14'h0000, dig: 8'h5C, ext: 8'h00, cnt: 16'h0000, exp: 8'h5C};
        vecs[6] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd4, 4'd0, 16'h0012), adc: 14'h0000, dig: 8'h00, ext: 8'h5A, cnt: 16'h0000, exp: 8'h5A};
        vecs[7] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd6, 4'd0, 16'h0000), adc: 14'h0000, dig: 8'h00, ext: 8'h00, cnt: 16'hBEEF, exp: 8'hBE};
        vecs[8] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd7, 4'd0, 16'h0000), adc: 14'h0000, dig: 8'h00, ext: 8'h00, cnt: 16'hBEEF, exp: 8'hEF};
        vecs[9] = '{cfg: mk_cfg(2'd0, 1'b0, 1'b0, 3'd5, 4'd0, 16'h01FF), adc: 14'h0000, dig: 8'h00, ext: 8'h00, cnt: 16'h0000, exp: 8'hFF};

        bus.Configer_Word  = mk_cfg(2'd0, 1'b0, 1'b0, 3'd5, 4'd0, 16'h00A5);
        bus.DataBus_Analog = '0;
        bus.DataBus_Digtal = '0;
        bus.DataBus_Extern = '0;
        bus.Counter_Frame  = '0;
        model_reset();

        // reset state and the default first word
        do_reset();
        chk("rst_pcm", 32'(bus.PCM), 32'd0);
        chk("rst_req", 32'(bus.Config_Req), 32'd0);
        chk("rst_k", 32'(bus.Bit_Index), 32'(WW - 1));
        wait_k(0);
        collect(WW, w);
        chk("first_word", w, 32'h0000_00AA);
        wait_k(0);
        collect(WW, w);
        chk("second_word", w, 32'h0000_00A5);
        wait_k(0);
        req_period(p);
        chk("req_period8", 32'(p), 32'd8);

        // parity even then odd
        bus.Configer_Word = mk_cfg(2'd0, 1'b1, 1'b0, 3'd5, 4'd0, 16'h0007);
        wait_k(2);
        wait_k(0);
        collect(WW + 1, w);
        chk("parity_even_word", w, 32'h0000_000F);
        wait_k(0);
        req_period(p);
        chk("req_period9", 32'(p), 32'd9);
        bus.Configer_Word = mk_cfg(2'd0, 1'b1, 1'b1, 3'd5, 4'd0, 16'h0007);
        wait_k(2);
        wait_k(0);
        collect(WW + 1, w);
        chk("parity_odd_word", w, 32'h0000_000E);

        // NRZ-M from level 0 right after reset
        bus.Configer_Word = mk_cfg(2'd1, 1'b0, 1'b0, 3'd5, 4'd0, 16'h00F0);
        do_reset();
        wait_k(0);
        collect(WW, w);
        chk("nrzm_lead_word", w, 32'h0000_00AA);
        wait_k(0);
        collect(WW, w);
        chk("nrzm_word", w, 32'h0000_00A0);

        // table of channel types in NRZ-L
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_vec(i);
            if (i == 1) chk("analog_id", 32'(bus.ID_Analog), 32'h15);
            if (i == 6) chk("extern_cs", 32'(bus.CS_Extern), 32'h12);
        end

        // reset in the middle of a word aborts it
        bus.Configer_Word  = mk_cfg(2'd0, 1'b0, 1'b0, 3'd4, 4'd0, 16'h0012);
        bus.DataBus_Extern = 8'hFF;
        wait_k(2);
        wait_k(0);
        wait_k(4);
        chk("pre_abort_pcm", 32'(bus.PCM), 32'd1);
        chk("pre_abort_cse", 32'(bus.CS_Extern), 32'h12);
        RESET = 1'b1;
        cycle();
        chk("abort_pcm", 32'(bus.PCM), 32'd0);
        chk("abort_cse", 32'(bus.CS_Extern), 32'd0);
        RESET = 1'b0;
        wait_k(0);
        collect(WW, w);
        chk("abort_first_word", w, 32'h0000_00AA);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.Configer_Word  = $urandom;
            bus.DataBus_Analog = AW'($urandom);
            bus.DataBus_Digtal = WW'($urandom);
            bus.DataBus_Extern = WW'($urandom);
            bus.Counter_Frame  = FW'($urandom);
            RESET = ($urandom_range(0, 499) == 0);
            cycle();
        end
        RESET = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
